// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Executes decoded ALU operations on operands A and B. Add, subtract, OR and
// the illegal-op response complete in a single cycle. The left shift is
// iterative and moves SHIFT_STEP bits per cycle. Operations arrive on a
// valid/ready handshake and results leave on another valid/ready handshake.
// Only one operation is in flight at a time.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   reset          synchronous, active-high reset
//   in_valid       an operation and its operands are presented
//   in_ready       the unit accepts an operation this cycle (state IDLE)
//   a, b           operands; b[SHAMT_W-1:0] is the shift amount for sll
//   result_select  0 add/sub, 1 or, 2 sll, 3 illegal
//   neg_b          subtract (a + ~b + 1); used by add/sub only
//   l_ctrl, s_ctrl reserved controls; captured on accept, no effect
//   out_valid      result is valid; held until out_ready
//   out_ready      consumer takes the result
//   result         operation result
//   illegal        the operation was result_select == 3
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       result_select,
  input  logic             neg_b,
  input  logic             l_ctrl,
  input  logic             s_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready=1
  // SHIFT | sll in progress, acc shifted each cycle until remaining=0
  // DONE  | result presented, out_valid=1 until out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]         SEL_ADD = 2'd0;
  localparam logic [1:0]         SEL_OR  = 2'd1;
  localparam logic [1:0]         SEL_SLL = 2'd2;
  localparam logic [SHAMT_W-1:0] STEP_W  = SHAMT_W'(SHIFT_STEP);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] remaining;
  logic [WIDTH-1:0]   result_q;
  logic               illegal_q;
  // Reserved controls are held for future use; the name keeps them out of
  // unused-signal reports.
  logic [1:0]         rsvd_ctrl_unused;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] rem_after;
  logic [WIDTH-1:0]   acc_shifted;
  logic [WIDTH-1:0]   b_operand;
  logic [WIDTH-1:0]   add_sum;

  assign accept      = in_valid & in_ready;
  assign shamt       = b[SHAMT_W-1:0];
  // Final step may be shorter than SHIFT_STEP so we never overshoot.
  assign step_amt    = (remaining < STEP_W) ? remaining : STEP_W;
  assign rem_after   = remaining - step_amt;
  assign acc_shifted = acc << step_amt;
  assign b_operand   = neg_b ? ~b : b;
  assign add_sum     = a + b_operand + {{(WIDTH-1){1'b0}}, neg_b};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (result_select == SEL_SLL && shamt != '0) state_nxt = SHIFT;
          else                                          state_nxt = DONE;
        end
      end
      SHIFT:   if (rem_after == '0) state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    result    = result_q;
    illegal   = illegal_q;
  end

  // Datapath: result only changes on accept or while shifting, so it stays
  // stable in DONE under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc              <= '0;
      remaining        <= '0;
      result_q         <= '0;
      illegal_q        <= 1'b0;
      rsvd_ctrl_unused <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            illegal_q        <= 1'b0;
            rsvd_ctrl_unused <= {l_ctrl, s_ctrl};
            case (result_select)
              SEL_ADD: result_q <= add_sum;
              SEL_OR:  result_q <= a | b;
              SEL_SLL: begin
                if (shamt == '0) begin
                  result_q <= a;
                end else begin
                  acc       <= a;
                  remaining <= shamt;
                end
              end
              default: begin
                result_q  <= '0;
                illegal_q <= 1'b1;
              end
            endcase
          end
        end
        SHIFT: begin
          acc       <= acc_shifted;
          remaining <= rem_after;
          if (rem_after == '0) result_q <= acc_shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed bench for alu_exec_unit. Expected results come from a small
// reference model, are queued when an operation is accepted and popped when
// the unit presents its result.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   result_select = 2'd0;
  logic         neg_b = 1'b0;
  logic         l_ctrl = 1'b0;
  logic         s_ctrl = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         illegal;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit #(.WIDTH(W), .SHAMT_W(5), .SHIFT_STEP(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .result_select (result_select),
    .neg_b         (neg_b),
    .l_ctrl        (l_ctrl),
    .s_ctrl        (s_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [1:0] isel, input logic ineg);
    exp_t e;
    e.ill = 1'b0;
    e.lat = 1;
    case (isel)
      2'd0: e.res = ineg ? (ia - ib) : (ia + ib);
      2'd1: e.res = ia | ib;
      2'd2: begin
        e.res = ia << ib[4:0];
        if (ib[4:0] != 5'd0) e.lat = 1 + int'(ib[4:0]);
      end
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Issues one operation, waits for its result and checks it against the
  // scoreboard. With out_ready=0 it returns while the result is held.
  task automatic issue(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [1:0] isel, input logic ineg);
    exp_t e;
    int   lat;
    int   busy_bad;
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    a = ia; b = ib; result_select = isel; neg_b = ineg;
    in_valid = 1'b1;
    sb.push_back(model(ia, ib, isel, ineg));
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; neg_b = 1'b1;
    lat = 1;
    busy_bad = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_bad++;
      tick();
      lat++;
    end
    chk({tag, "_out_valid"}, W'(out_valid), W'(1));
    chk({tag, "_busy_in_ready"}, W'(busy_bad + int'(in_ready)), W'(0));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, W'(0), W'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, W'(lat), W'(e.lat));
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_illegal"}, W'(illegal), W'(e.ill));
    end
    if (out_ready) begin
      tick();
      chk({tag, "_release_valid"}, W'(out_valid), W'(0));
      chk({tag, "_release_ready"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    int seen;
    logic [1:0] rsel;
    logic [W-1:0] ra, rb;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    chk("rst_illegal", W'(illegal), W'(0));

    issue("add", 32'd7, 32'd5, 2'd0, 1'b0);
    issue("sub_wrap", 32'd0, 32'd1, 2'd0, 1'b1);
    issue("sub", 32'd10, 32'd3, 2'd0, 1'b1);
    issue("or_negb", 32'hA0A0_0000, 32'h0000_0505, 2'd1, 1'b1);
    issue("sll31", 32'd1, 32'd31, 2'd2, 1'b0);
    issue("sll_shamt0", 32'd1, 32'h20, 2'd2, 1'b0);
    issue("sll_upper_b", 32'h0000_00F3, 32'hFFFF_FFE4, 2'd2, 1'b1);
    issue("illegal", 32'hFFFF, 32'hFFFF, 2'd3, 1'b0);
    issue("add_clears_ill", 32'd3, 32'd4, 2'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rsel = 2'($urandom_range(0, 2));
      ra = $urandom;
      rb = $urandom;
      issue("rand", ra, rb, rsel, 1'($urandom_range(0, 1)));
    end

    // Backpressure: result held, new operations refused
    out_ready = 1'b0;
    issue("bp_or", 32'hF0, 32'h0F, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 32'd1; b = 32'd1; result_select = 2'd3; neg_b = 1'b0;
      tick();
      chk("bp_hold_result", result, 32'hFF);
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_hold_illegal", W'(illegal), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", W'(out_valid), W'(0));
    chk("bp_release_ready", W'(in_ready), W'(1));
    issue("after_bp", 32'd2, 32'd2, 2'd0, 1'b0);

    // Reset in the middle of a shift
    a = 32'd1; b = 32'd20; result_select = 2'd2; neg_b = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_sll_busy", W'(in_ready), W'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_result", result, '0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("mid_rst_no_output", W'(seen), W'(0));
    issue("after_rst", 32'h1234_0000, 32'h0000_5678, 2'd0, 1'b0);

    chk("sb_drained", W'(sb.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
